// File: rtl/lc3_stack_seq.sv
// LC-3 stack sequencer: drives the stack-pointer unit, R6, MAR/MDR and PSR/PC loads
// through interrupt/exception entry and RTI, handing control back to the main control unit on done.
module lc3_stack_seq #(
    parameter logic [2:0]  SP_REG      = 3'd6,
    parameter int unsigned RDY_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       rti_req,
    input  logic       psr_priv,
    input  logic       mem_rdy,
    output logic       busy,
    output logic       done,
    output logic       priv_exc,
    output logic       mem_err,
    output logic [2:0] sr1_sel,
    output logic [2:0] dr_sel,
    output logic       ld_reg,
    output logic       ld_saved_usp,
    output logic       ld_saved_ssp,
    output logic       gate_sp,
    output logic [1:0] spmux,
    output logic       ld_mar,
    output logic       ld_mar_sr1,
    output logic       mem_en,
    output logic       mem_we,
    output logic       gate_psr,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       ld_pc,
    output logic       ld_psr,
    output logic       set_super
);

    localparam int CNT_W = (RDY_TIMEOUT > 0) ? $clog2(RDY_TIMEOUT + 1) : 1;

    localparam logic [1:0] SPMUX_USP = 2'b00;
    localparam logic [1:0] SPMUX_INC = 2'b01;
    localparam logic [1:0] SPMUX_DEC = 2'b10;
    localparam logic [1:0] SPMUX_SSP = 2'b11;

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        ENTRY     = 5'd1,
        SAVE_USP  = 5'd2,
        LOAD_SSP  = 5'd3,
        DEC1      = 5'd4,
        WR_PSR    = 5'd5,
        DEC2      = 5'd6,
        WR_PC     = 5'd7,
        SET_SUP   = 5'd8,
        POP_PC_A  = 5'd9,
        RD_PC     = 5'd10,
        INC1      = 5'd11,
        POP_PSR_A = 5'd12,
        RD_PSR    = 5'd13,
        INC2      = 5'd14,
        CHK       = 5'd15,
        SAVE_SSP  = 5'd16,
        LOAD_USP  = 5'd17
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_mem;
    logic             timeout;

    assign in_mem  = (state == WR_PSR) || (state == WR_PC) ||
                     (state == RD_PC)  || (state == RD_PSR);
    assign timeout = (RDY_TIMEOUT > 0) && in_mem && !mem_rdy &&
                     (wait_cnt == CNT_W'(RDY_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter saturates so an unbounded wait (RDY_TIMEOUT=0) never wraps into a false match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_mem || (state_nxt != state)) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        priv_exc     = 1'b0;
        mem_err      = 1'b0;
        sr1_sel      = 3'd0;
        dr_sel       = 3'd0;
        ld_reg       = 1'b0;
        ld_saved_usp = 1'b0;
        ld_saved_ssp = 1'b0;
        gate_sp      = 1'b0;
        spmux        = SPMUX_USP;
        ld_mar       = 1'b0;
        ld_mar_sr1   = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        gate_psr     = 1'b0;
        gate_pc      = 1'b0;
        gate_mdr     = 1'b0;
        ld_pc        = 1'b0;
        ld_psr       = 1'b0;
        set_super    = 1'b0;

        unique case (state)
            IDLE: begin
                if (int_req) begin
                    state_nxt = ENTRY;
                end else if (rti_req) begin
                    // priv_exc is the only input-driven output in IDLE; keep it quiet under reset.
                    if (psr_priv) priv_exc = rst_n;
                    else          state_nxt = POP_PC_A;
                end
            end
            ENTRY: begin
                busy      = 1'b1;
                state_nxt = psr_priv ? SAVE_USP : DEC1;
            end
            SAVE_USP: begin
                busy         = 1'b1;
                ld_saved_usp = 1'b1;
                state_nxt    = LOAD_SSP;
            end
            LOAD_SSP: begin
                busy      = 1'b1;
                gate_sp   = 1'b1;
                spmux     = SPMUX_SSP;
                ld_reg    = 1'b1;
                state_nxt = DEC1;
            end
            DEC1, DEC2: begin
                busy      = 1'b1;
                gate_sp   = 1'b1;
                spmux     = SPMUX_DEC;
                ld_reg    = 1'b1;
                ld_mar    = 1'b1;
                state_nxt = (state == DEC1) ? WR_PSR : WR_PC;
            end
            WR_PSR, WR_PC: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    busy     = 1'b1;
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    gate_psr = (state == WR_PSR);
                    gate_pc  = (state == WR_PC);
                    if (mem_rdy) state_nxt = (state == WR_PSR) ? DEC2 : SET_SUP;
                end
            end
            SET_SUP: begin
                busy      = 1'b1;
                set_super = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            POP_PC_A, POP_PSR_A: begin
                busy       = 1'b1;
                ld_mar_sr1 = 1'b1;
                state_nxt  = (state == POP_PC_A) ? RD_PC : RD_PSR;
            end
            RD_PC, RD_PSR: begin
                if (timeout) begin
                    mem_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    busy   = 1'b1;
                    mem_en = 1'b1;
                    if (mem_rdy) begin
                        gate_mdr  = 1'b1;
                        ld_pc     = (state == RD_PC);
                        ld_psr    = (state == RD_PSR);
                        state_nxt = (state == RD_PC) ? INC1 : INC2;
                    end
                end
            end
            INC1, INC2: begin
                busy      = 1'b1;
                gate_sp   = 1'b1;
                spmux     = SPMUX_INC;
                ld_reg    = 1'b1;
                state_nxt = (state == INC1) ? POP_PSR_A : CHK;
            end
            CHK: begin
                busy = 1'b1;
                if (psr_priv) begin
                    state_nxt = SAVE_SSP;
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SAVE_SSP: begin
                busy         = 1'b1;
                ld_saved_ssp = 1'b1;
                state_nxt    = LOAD_USP;
            end
            LOAD_USP: begin
                busy      = 1'b1;
                gate_sp   = 1'b1;
                spmux     = SPMUX_USP;
                ld_reg    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (busy) begin
            sr1_sel = SP_REG;
            dr_sel  = SP_REG;
        end
    end

    a_bus_single_driver: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({gate_sp, gate_psr, gate_pc, gate_mdr}));

endmodule

// File: doc/lc3_stack_seq.md
Name: lc3_stack_seq

Overview:
- Control FSM that sequences the LC-3 stack-pointer unit, the register file (R6), MAR/MDR and PSR/PC loads.
- Handles two multi-cycle operations: interrupt/exception entry and RTI.
- Entry: switches to the supervisor stack if needed, then pushes PSR and PC.
- RTI: pops PC and PSR, then switches back to the user stack if the restored PSR is user mode.
- Sits beside the main control unit; the main control unit hands over on a request and resumes after done.

Parameters:
- SP_REG, 3'd6: register-file index used as the stack pointer.
- RDY_TIMEOUT, 0: maximum cycles to wait for mem_rdy; 0 means wait forever.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- int_req  in  1  start interrupt/exception entry; sampled only in IDLE.
- rti_req  in  1  start RTI; sampled only in IDLE.
- psr_priv  in  1  PSR[15] (1 = user mode), reflecting the current PSR register.
- mem_rdy  in  1  memory access complete.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- priv_exc  out  1  one-cycle pulse when RTI is requested in user mode.
- mem_err  out  1  one-cycle pulse on mem_rdy timeout.
- sr1_sel  out  3  SR1 address; SP_REG whenever busy, else 0.
- dr_sel  out  3  destination register; SP_REG whenever busy, else 0.
- ld_reg  out  1  write the bus value to dr_sel.
- ld_saved_usp  out  1  SavedUSP <- SR1OUT.
- ld_saved_ssp  out  1  SavedSSP <- SR1OUT.
- gate_sp  out  1  stack-pointer unit drives the bus.
- spmux  out  2  stack-pointer mux select: 00 SavedUSP, 01 SR1+1, 10 SR1-1, 11 SavedSSP.
- ld_mar  out  1  MAR <- bus.
- ld_mar_sr1  out  1  MAR <- SR1OUT.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- gate_psr  out  1  PSR drives the bus; data for the PSR push.
- gate_pc  out  1  PC drives the bus; data for the PC push.
- gate_mdr  out  1  MDR drives the bus; read data.
- ld_pc  out  1  PC <- bus.
- ld_psr  out  1  PSR <- bus.
- set_super  out  1  PSR[15] <- 0.

Behaviour:
- Reset and defaults
  - Reset (async assert) forces state IDLE and every output 0.
  - A reset mid-operation abandons the sequence; R6 and memory contents are left as-is.
  - All outputs are Moore-decoded from the state, except the mem_rdy-qualified pulses noted below.
  - Any output not listed for a state is 0.
- IDLE
  - If int_req=1, go to ENTRY (int_req wins over a simultaneous rti_req; that rti_req is dropped).
  - Else if rti_req=1: if psr_priv=1, pulse priv_exc and stay in IDLE; otherwise go to POP_PC_A.
- Interrupt entry
  - ENTRY: if psr_priv=1, go to SAVE_USP; else go to DEC1.
  - SAVE_USP: ld_saved_usp. Next state LOAD_SSP.
  - LOAD_SSP: gate_sp, spmux=11, ld_reg. Next state DEC1.
  - DEC1: gate_sp, spmux=10, ld_reg, ld_mar. R6 and MAR both become R6-1. Next state WR_PSR.
  - WR_PSR: mem_en, mem_we, gate_psr held until mem_rdy=1, then go to DEC2.
  - DEC2: same outputs as DEC1. Next state WR_PC.
  - WR_PC: mem_en, mem_we, gate_pc held until mem_rdy=1, then go to SET_SUP.
  - SET_SUP: set_super, done. Next state IDLE.
  - Total entry: 6 cycles (supervisor mode) or 8 cycles (user mode), plus memory wait cycles.
- RTI
  - POP_PC_A: ld_mar_sr1. Next state RD_PC.
  - RD_PC: mem_en held. gate_mdr and ld_pc are asserted only in the cycle with mem_rdy=1; then go to INC1.
  - INC1: gate_sp, spmux=01, ld_reg. Next state POP_PSR_A.
  - POP_PSR_A: ld_mar_sr1. Next state RD_PSR.
  - RD_PSR: mem_en held. gate_mdr and ld_psr are asserted only in the cycle with mem_rdy=1; then go to INC2.
  - INC2: same outputs as INC1. Next state CHK.
  - CHK: psr_priv now reflects the restored PSR. If 1, go to SAVE_SSP; else pulse done and go to IDLE.
  - SAVE_SSP: ld_saved_ssp. Next state LOAD_USP.
  - LOAD_USP: gate_sp, spmux=00, ld_reg, done. Next state IDLE.
- Bus rule: at most one of gate_sp, gate_psr, gate_pc, gate_mdr is high in any cycle (checked by assertion).
- Timeout
  - The wait counter counts cycles spent in a memory state and clears on every state change.
  - If RDY_TIMEOUT>0 and the counter reaches RDY_TIMEOUT with mem_rdy=0: pulse mem_err, deassert all outputs, go to IDLE.
- Requests arriving while busy are ignored, not queued.

Test Plan:
- Entry from user mode (psr_priv=1, R6=x3000 user, SavedSSP=x3000-side value x2FFF+1=x3000, mem_rdy tied 1) -> visit order SAVE_USP, LOAD_SSP, DEC1, WR_PSR, DEC2, WR_PC, SET_SUP. SavedUSP=x3000, pushes land at x2FFF (PSR) and x2FFE (PC), final R6=x2FFE, done asserted at cycle 8.
- Entry from supervisor mode (psr_priv=0, R6=x2FF0) -> no ld_saved_usp, writes at x2FEF and x2FEE, final R6=x2FEE, done asserted at cycle 6.
- RTI to user (R6=x2FFE, mem[x2FFE]=x3050, mem[x2FFF]=x8002) -> PC=x3050, PSR=x8002, SavedSSP=x3000, R6=SavedUSP; done pulses once.
- RTI in user mode (psr_priv=1) -> priv_exc pulses 1 cycle, busy stays 0, no memory access.
- mem_rdy delayed 3 cycles in WR_PSR, RDY_TIMEOUT=0 -> mem_en/mem_we/gate_psr held 4 cycles, no early DEC2. With RDY_TIMEOUT=2 and mem_rdy never asserted -> mem_err pulses after 2 wait cycles, back to IDLE.
- int_req and rti_req asserted together in IDLE -> entry sequence runs. rst_n dropped during WR_PC -> all outputs 0 immediately, state IDLE after release.
